// File: rtl/sram_access_ctrl.sv
// SRAM byte access controller: latches a host address, runs timed read/write strobes, auto-increments.
// Latency: req/addr_load edges act 3 clocks after the input rises; an access takes 1 + WAIT_CYCLES + 1 clocks to ack.
// Backpressure: none; a req edge arriving while busy is dropped and flagged in the sticky overrun bit.
module sram_access_ctrl #(
    parameter int AWIDTH      = 21,
    parameter int DWIDTH      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [AWIDTH-1:0] sreg_addr,
    input  logic              addr_load,
    input  logic              req,
    input  logic              rw,
    input  logic [DWIDTH-1:0] wdata,
    output logic [DWIDTH-1:0] rdata,
    output logic              ack,
    output logic              busy,
    output logic              overrun,
    output logic [AWIDTH-1:0] sram_addr,
    output logic [DWIDTH-1:0] sram_data_o,
    output logic              sram_data_oe,
    input  logic [DWIDTH-1:0] sram_data_i,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    // A zero strobe width would give no cycle to sample read data, so it is promoted to one.
    localparam int EFF_WAIT = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CW       = (EFF_WAIT > 1) ? $clog2(EFF_WAIT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(EFF_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     cnt_q;
    logic              rw_q;
    logic [DWIDTH-1:0] wdata_q;
    logic [AWIDTH-1:0] addr_q;
    logic [AWIDTH-1:0] pend_addr_q;
    logic              pend_q;
    logic              req_s1, req_s2, req_s3;
    logic              load_s1, load_s2, load_s3;
    logic              req_rise;
    logic              load_rise;
    logic              last_strobe;

    assign req_rise    = req_s2 & ~req_s3;
    assign load_rise   = load_s2 & ~load_s3;
    assign last_strobe = (state_q == STROBE) && (cnt_q == '0);

    // Two-flop synchronizers for the host strobes plus a delay stage for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_s1  <= 1'b0;
            req_s2  <= 1'b0;
            req_s3  <= 1'b0;
            load_s1 <= 1'b0;
            load_s2 <= 1'b0;
            load_s3 <= 1'b0;
        end else begin
            req_s1  <= req;
            req_s2  <= req_s1;
            req_s3  <= req_s2;
            load_s1 <= addr_load;
            load_s2 <= load_s1;
            load_s3 <= load_s2;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> SETUP -> STROBE (counted) -> HOLD -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_rise) state_d = SETUP;
            SETUP:   state_d = STROBE;
            STROBE:  if (cnt_q == '0) state_d = HOLD;
            HOLD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pad controls decoded straight from the state register so reset forces them inactive at once.
    always_comb begin
        busy         = (state_q != IDLE);
        ack          = (state_q == HOLD);
        sram_ce_n    = (state_q == IDLE);
        sram_oe_n    = !((state_q == STROBE) && rw_q);
        sram_we_n    = !((state_q == STROBE) && !rw_q);
        sram_data_oe = !rw_q && (state_q != IDLE);
        sram_data_o  = wdata_q;
        sram_addr    = addr_q;
    end

    // Strobe-width down-counter, loaded as SETUP hands over to STROBE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (state_q == SETUP) begin
            cnt_q <= CNT_INIT;
        end else if ((state_q == STROBE) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Capture direction and write data when an access is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rw_q    <= 1'b1;
            wdata_q <= '0;
        end else if ((state_q == IDLE) && req_rise) begin
            rw_q    <= rw;
            wdata_q <= wdata;
        end
    end

    // Read data is sampled at the end of the last strobe cycle, while oe_n is still low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (last_strobe && rw_q) begin
            rdata <= sram_data_i;
        end
    end

    // Loads arriving mid-access are parked until HOLD so the running cycle keeps a stable address.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else if (load_rise && (state_q == SETUP || state_q == STROBE)) begin
            pend_q      <= 1'b1;
            pend_addr_q <= sreg_addr;
        end else if (state_q == HOLD) begin
            pend_q      <= 1'b0;
        end
    end

    // Address counter: direct load in IDLE, and in HOLD a new/parked load wins over the increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_q <= '0;
        end else if (state_q == IDLE) begin
            if (load_rise) addr_q <= sreg_addr;
        end else if (state_q == HOLD) begin
            if (load_rise)   addr_q <= sreg_addr;
            else if (pend_q) addr_q <= pend_addr_q;
            else             addr_q <= addr_q + AWIDTH'(1);
        end
    end

    // Sticky overrun: set by a req edge outside IDLE, cleared by any load edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun <= 1'b0;
        end else if (load_rise) begin
            overrun <= 1'b0;
        end else if (req_rise && (state_q != IDLE)) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: default instance plus a WAIT_CYCLES=0 instance sharing all inputs.
// Latency: inputs driven 1ns after a posedge, outputs sampled at the same point after each posedge.
// Backpressure: none; every wait for a DUT event is bounded by a cycle budget.
module tb_sram_access_ctrl;

    localparam int AW = 21;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [AW-1:0] sreg_addr;
    logic          addr_load;
    logic          req;
    logic          rw;
    logic [DW-1:0] wdata;

    logic [DW-1:0] rdata, rdata_z;
    logic          ack, ack_z, busy, busy_z, overrun, overrun_z;
    logic [AW-1:0] sram_addr, sram_addr_z;
    logic [DW-1:0] sram_data_o, sram_data_o_z, sram_data_i, sram_data_i_z;
    logic          sram_data_oe, sram_data_oe_z;
    logic          sram_ce_n, sram_ce_n_z, sram_oe_n, sram_oe_n_z, sram_we_n, sram_we_n_z;

    always #5 clk = ~clk;

    sram_access_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .WAIT_CYCLES(2)) dut (
        .clk(clk), .reset_n(reset_n), .sreg_addr(sreg_addr), .addr_load(addr_load),
        .req(req), .rw(rw), .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy),
        .overrun(overrun), .sram_addr(sram_addr), .sram_data_o(sram_data_o),
        .sram_data_oe(sram_data_oe), .sram_data_i(sram_data_i), .sram_ce_n(sram_ce_n),
        .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n)
    );

    sram_access_ctrl #(.AWIDTH(AW), .DWIDTH(DW), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .reset_n(reset_n), .sreg_addr(sreg_addr), .addr_load(addr_load),
        .req(req), .rw(rw), .wdata(wdata), .rdata(rdata_z), .ack(ack_z), .busy(busy_z),
        .overrun(overrun_z), .sram_addr(sram_addr_z), .sram_data_o(sram_data_o_z),
        .sram_data_oe(sram_data_oe_z), .sram_data_i(sram_data_i_z), .sram_ce_n(sram_ce_n_z),
        .sram_oe_n(sram_oe_n_z), .sram_we_n(sram_we_n_z)
    );

    // SRAM contents: a few fixed bytes, everything else derived from the address.
    function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
        case (a)
            21'h000010: return 8'h11;
            21'h000011: return 8'h22;
            21'h000012: return 8'h33;
            21'h1FFFFF: return 8'hEE;
            default:    return a[7:0] ^ 8'h5C;
        endcase
    endfunction

    assign sram_data_i   = model_rd(sram_addr);
    assign sram_data_i_z = model_rd(sram_addr_z);

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pad invariants on both instances, every cycle out of reset.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            check("oe_we_excl",   32'(sram_oe_n | sram_we_n), 32'd1);
            check("oe_no_drive",  32'(!(!sram_oe_n && sram_data_oe)), 32'd1);
            check("z_oe_we_excl", 32'(sram_oe_n_z | sram_we_n_z), 32'd1);
            check("z_oe_no_drive", 32'(!(!sram_oe_n_z && sram_data_oe_z)), 32'd1);
        end
    end

    // Per-access observations filled in by do_access.
    int            busy_cnt, we_cnt, oe_cnt, ack_cnt, ack_idx, we_oe_bad;
    int            busy_cnt_z, oe_cnt_z, ack_cnt_z;
    logic [AW-1:0] strobe_addr, strobe_addr_z;
    logic [DW-1:0] strobe_data;

    task automatic load_addr(input logic [AW-1:0] a);
        sreg_addr = a;
        addr_load = 1'b1;
        repeat (3) tick();
        check("load_addr", 32'(sram_addr), 32'(a));
        addr_load = 1'b0;
        repeat (3) tick();
    endtask

    task automatic do_access(input logic r, input logic [DW-1:0] wd,
                             input logic with_load, input logic [AW-1:0] la);
        bit seen = 0;
        bit done = 0;
        busy_cnt = 0; we_cnt = 0; oe_cnt = 0; ack_cnt = 0; ack_idx = 0; we_oe_bad = 0;
        busy_cnt_z = 0; oe_cnt_z = 0; ack_cnt_z = 0;
        strobe_addr = '0; strobe_addr_z = '0; strobe_data = '0;
        rw    = r;
        wdata = wd;
        if (with_load) begin
            sreg_addr = la;
            addr_load = 1'b1;
        end
        req = 1'b1;
        for (int i = 0; i < 30 && !done; i++) begin
            tick();
            if (busy) begin
                seen = 1;
                busy_cnt++;
            end
            if (!sram_we_n) begin
                we_cnt++;
                strobe_addr = sram_addr;
                strobe_data = sram_data_o;
                if (!sram_data_oe) we_oe_bad++;
            end
            if (!sram_oe_n) begin
                oe_cnt++;
                strobe_addr = sram_addr;
            end
            if (ack) begin
                ack_cnt++;
                ack_idx = busy_cnt;
            end
            if (busy_z) busy_cnt_z++;
            if (!sram_oe_n_z) begin
                oe_cnt_z++;
                strobe_addr_z = sram_addr_z;
            end
            if (ack_z) ack_cnt_z++;
            if (seen && !busy) done = 1;
        end
        check("acc_done", 32'(done), 32'd1);
        req       = 1'b0;
        addr_load = 1'b0;
        repeat (3) tick();
    endtask

    logic [DW-1:0] exp_rd [3] = '{8'h11, 8'h22, 8'h33};

    initial begin
        int found;
        int busy_seen;
        reset_n = 1'b0; sreg_addr = '0; addr_load = 1'b0; req = 1'b0; rw = 1'b0; wdata = '0;

        // Reset state
        repeat (3) tick();
        check("rst_ce_n", 32'(sram_ce_n), 32'd1);
        check("rst_oe_n", 32'(sram_oe_n), 32'd1);
        check("rst_we_n", 32'(sram_we_n), 32'd1);
        check("rst_data_oe", 32'(sram_data_oe), 32'd0);
        check("rst_data_o", 32'(sram_data_o), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_flags", 32'({ack, busy, overrun}), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();
        check("idle_busy", 32'(busy), 32'd0);

        // Load + write
        load_addr(21'h0ABCDE);
        do_access(1'b0, 8'h5A, 1'b0, '0);
        check("wr_we_cycles", 32'(we_cnt), 32'd2);
        check("wr_addr", 32'(strobe_addr), 32'h0ABCDE);
        check("wr_data", 32'(strobe_data), 32'h5A);
        check("wr_oe_during_we", 32'(we_oe_bad), 32'd0);
        check("wr_no_oe", 32'(oe_cnt), 32'd0);
        check("wr_ack_pulses", 32'(ack_cnt), 32'd1);
        check("wr_ack_cycle", 32'(ack_idx), 32'd4);
        check("wr_busy_cycles", 32'(busy_cnt), 32'd4);
        check("wr_addr_inc", 32'(sram_addr), 32'h0ABCDF);

        // Streaming reads
        load_addr(21'h000010);
        for (int k = 0; k < 3; k++) begin
            do_access(1'b1, 8'h00, 1'b0, '0);
            check("rd_oe_cycles", 32'(oe_cnt), 32'd2);
            check("rd_no_we", 32'(we_cnt), 32'd0);
            check("rd_ack_pulses", 32'(ack_cnt), 32'd1);
            check("rd_data", 32'(rdata), 32'(exp_rd[k]));
        end
        check("rd_final_addr", 32'(sram_addr), 32'h000013);

        // Address wrap
        load_addr(21'h1FFFFF);
        do_access(1'b1, 8'h00, 1'b0, '0);
        check("wrap_rdata", 32'(rdata), 32'hEE);
        check("wrap_addr", 32'(sram_addr), 32'h000000);

        // Overrun and deferred load: req pulse, second req edge acts in STROBE1, load edge in STROBE2
        load_addr(21'h000200);
        rw  = 1'b1;
        req = 1'b1; tick();
        req = 1'b0; tick();
        req = 1'b1; tick();
        check("ovr_started", 32'(busy), 32'd1);
        sreg_addr = 21'h000100;
        addr_load = 1'b1;
        tick();
        tick();
        check("ovr_set", 32'(overrun), 32'd1);
        check("ovr_still_busy", 32'(busy), 32'd1);
        tick();
        check("ovr_ack", 32'(ack), 32'd1);
        check("ovr_cleared_by_load", 32'(overrun), 32'd0);
        check("ovr_addr_held", 32'(sram_addr), 32'h000200);
        tick();
        check("ovr_deferred_addr", 32'(sram_addr), 32'h000100);
        check("ovr_after_ack", 32'(overrun), 32'd0);
        check("ovr_idle", 32'(busy), 32'd0);
        busy_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (busy) busy_seen++;
        end
        check("ovr_no_second_access", 32'(busy_seen), 32'd0);
        req = 1'b0; addr_load = 1'b0;
        repeat (3) tick();

        // Asynchronous reset in the middle of a write strobe
        load_addr(21'h000333);
        rw = 1'b0; wdata = 8'hA7; req = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && found == 0; i++) begin
            tick();
            if (!sram_we_n) found = 1;
        end
        check("mid_strobe_reached", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        check("arst_we_n", 32'(sram_we_n), 32'd1);
        check("arst_ce_n", 32'(sram_ce_n), 32'd1);
        check("arst_data_oe", 32'(sram_data_oe), 32'd0);
        check("arst_data_o", 32'(sram_data_o), 32'd0);
        req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        check("arst_addr", 32'(sram_addr), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        repeat (3) tick();
        check("arst_no_restart", 32'(busy), 32'd0);

        // Coincident load and req edges; second instance has WAIT_CYCLES = 0
        do_access(1'b1, 8'h00, 1'b1, 21'h0000AA);
        check("coin_addr", 32'(strobe_addr), 32'h0000AA);
        check("coin_rdata", 32'(rdata), 32'hF6);
        check("coin_oe_cycles", 32'(oe_cnt), 32'd2);
        check("coin_addr_inc", 32'(sram_addr), 32'h0000AB);
        check("w0_oe_cycles", 32'(oe_cnt_z), 32'd1);
        check("w0_busy_cycles", 32'(busy_cnt_z), 32'd3);
        check("w0_ack_pulses", 32'(ack_cnt_z), 32'd1);
        check("w0_addr", 32'(strobe_addr_z), 32'h0000AA);
        check("w0_rdata", 32'(rdata_z), 32'hF6);
        check("w0_addr_inc", 32'(sram_addr_z), 32'h0000AB);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
